datapath_ctrl_fsm: RTL and testbench



---
 rtl/datapath_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_datapath_ctrl_fsm.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle controller: accepts 12-bit instructions and sequences datapath_4bits controls.
// Optional macro DPC_CMP_EN turns class 10 into a compare (flags only, no write); otherwise NOP.
module datapath_ctrl_fsm #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] dp_result,
  input  logic              dp_carry_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              write_enable,
  output logic              sel12,
  output logic              sel21,
  output logic [2:0]        opcode,
  output logic              carry_in,
  output logic [DATA_W-1:0] dados,
  output logic              done,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              illegal
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_A, RD_B, CAP_B, WB, FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [9:0]        r_instr;
  logic              r_zero;
  logic              r_carry;
  logic              r_illegal;
  logic              w_xfer;
  logic              w_isCmp;
  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_srcA;
  logic [ADDR_W-1:0] w_srcB;
  logic              w_cin;
  logic [ADDR_W-1:0] w_ldDst;
  logic [DATA_W-1:0] w_imm;

  assign instr_ready = (r_state == IDLE) && !rst;
  assign w_xfer      = instr_valid && instr_ready;

  assign w_op    = r_instr[9:7];
  assign w_dst   = r_instr[6:5];
  assign w_srcA  = r_instr[4:3];
  assign w_srcB  = r_instr[2:1];
  assign w_cin   = r_instr[0];
  assign w_ldDst = r_instr[9:8];
  assign w_imm   = r_instr[3:0];

`ifdef DPC_CMP_EN
  logic r_cmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cmp <= 1'b0;
    else if (w_xfer) r_cmp <= (instr[11:10] == 2'b10);
  end

  assign w_isCmp = r_cmp;
`else
  assign w_isCmp = 1'b0;
`endif

  // The instruction is only captured on a handshake; the class bits are consumed there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_instr <= instr[9:0];
        if (instr[11:10] == 2'b11) r_illegal <= 1'b1;
      end
      if (r_state == WB) begin
        r_zero  <= (dp_result == '0);
        r_carry <= dp_carry_out;
      end
    end
  end

  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
  assign illegal    = r_illegal;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          case (instr[11:10])
            2'b00:   w_next = LOAD;
            2'b01:   w_next = RD_A;
`ifdef DPC_CMP_EN
            2'b10:   w_next = RD_A;
`else
            2'b10:   w_next = FIN;
`endif
            default: w_next = FIN;
          endcase
        end
      end
      LOAD:    w_next = FIN;
      RD_A:    w_next = RD_B;
      RD_B:    w_next = CAP_B;
      CAP_B:   w_next = WB;
      WB:      w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read phases keep write_enable low so register-file reads never disturb its contents.
  always_comb begin
    reg_addr     = '0;
    write_enable = 1'b0;
    sel12        = 1'b0;
    sel21        = 1'b0;
    opcode       = '0;
    carry_in     = 1'b0;
    dados        = '0;
    done         = 1'b0;
    case (r_state)
      LOAD: begin
        reg_addr     = w_ldDst;
        dados        = w_imm;
        write_enable = 1'b1;
      end
      RD_A: begin
        reg_addr = w_srcA;
        opcode   = w_op;
        carry_in = w_cin;
      end
      RD_B: begin
        reg_addr = w_srcB;
        opcode   = w_op;
        carry_in = w_cin;
      end
      CAP_B: begin
        reg_addr = w_srcB;
        sel12    = 1'b1;
        opcode   = w_op;
        carry_in = w_cin;
      end
      WB: begin
        reg_addr     = w_dst;
        sel12        = 1'b1;
        sel21        = 1'b1;
        opcode       = w_op;
        carry_in     = w_cin;
        write_enable = !w_isCmp;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Directed bench for datapath_ctrl_fsm with a small behavioural datapath_4bits model attached.
// Expectations follow DPC_CMP_EN when the macro is defined for the build.
module tb_datapath_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  dp_result;
  logic        dp_carry_out;
  logic [1:0]  reg_addr;
  logic        write_enable, sel12, sel21, carry_in, done;
  logic [2:0]  opcode;
  logic [3:0]  dados;
  logic        zero_flag, carry_flag, illegal;

  int checks = 0;
  int errors = 0;

  datapath_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dp_result(dp_result), .dp_carry_out(dp_carry_out),
    .reg_addr(reg_addr), .write_enable(write_enable), .sel12(sel12), .sel21(sel21),
    .opcode(opcode), .carry_in(carry_in), .dados(dados), .done(done),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Datapath model: registered register-file read, r0/r1 operand latches, op 000 = add, else AND.
  logic [3:0] rf [0:3] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] rdReg = '0, r0m = '0, r1m = '0;
  int         writeCount = 0;
  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, r0m} + {1'b0, r1m} + {4'd0, carry_in};
    if (opcode == 3'b000) begin
      dp_result    = sum[3:0];
      dp_carry_out = sum[4];
    end else begin
      dp_result    = r0m & r1m;
      dp_carry_out = 1'b0;
    end
  end

  always @(posedge clk) begin
    rdReg <= rf[reg_addr];
    if (!sel12) r0m <= rdReg;
    else        r1m <= rdReg;
    if (write_enable) begin
      rf[reg_addr] <= sel21 ? dp_result : dados;
      writeCount   <= writeCount + 1;
    end
  end

  logic [14:0] ctl;
  assign ctl = {instr_ready, done, write_enable, reg_addr, sel12, sel21, opcode, carry_in, dados};

  function automatic logic [14:0] mk(input logic rdy, input logic dn, input logic we,
                                     input logic [1:0] a, input logic s12, input logic s21,
                                     input logic [2:0] op, input logic cin, input logic [3:0] d);
    return {rdy, dn, we, a, s12, s21, op, cin, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] zeroCtl;
    zeroCtl = '0;
    repeat (2) tick();
    checks++;
    if (ctl !== zeroCtl) begin
      errors++;
      $display("[TB] FAIL reset_ctl got %h expected %h", ctl, zeroCtl);
    end
    checks++;
    if ({zero_flag, carry_flag, illegal} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 000", {zero_flag, carry_flag, illegal});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b expected 1", instr_ready);
    end
    tick();
  endtask

  task automatic test_load;
    logic [14:0] e [0:5];
    e[0] = mk(0, 0, 1, 2'd0, 0, 0, 3'd0, 0, 4'd7);
    e[1] = mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[2] = mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[3] = mk(0, 0, 1, 2'd1, 0, 0, 3'd0, 0, 4'd1);
    e[4] = mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[5] = mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send(12'h007);
      else if (i == 3) send(12'h101);
      else tick();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("[TB] FAIL load_cyc%0d ctl got %h expected %h", i, ctl, e[i]);
      end
    end
    checks++;
    if (rf[0] !== 4'd7 || rf[1] !== 4'd1) begin
      errors++;
      $display("[TB] FAIL load_rf got r0=%h r1=%h expected r0=7 r1=1", rf[0], rf[1]);
    end
  endtask

  task automatic test_alu_add;
    logic [14:0] e [0:5];
    e[0] = mk(0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[1] = mk(0, 0, 0, 2'd1, 0, 0, 3'd0, 0, 4'd0);
    e[2] = mk(0, 0, 0, 2'd1, 1, 0, 3'd0, 0, 4'd0);
    e[3] = mk(0, 0, 1, 2'd2, 1, 1, 3'd0, 0, 4'd0);
    e[4] = mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[5] = mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send(12'h442);
      else tick();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("[TB] FAIL add_cyc%0d ctl got %h expected %h", i, ctl, e[i]);
      end
      if (i == 3) begin
        checks++;
        if (dp_result !== 4'd8) begin
          errors++;
          $display("[TB] FAIL add_result got %h expected 8", dp_result);
        end
      end
    end
    checks++;
    if ({zero_flag, carry_flag} !== 2'b00 || rf[2] !== 4'd8) begin
      errors++;
      $display("[TB] FAIL add_flags got z=%b c=%b r2=%h expected z=0 c=0 r2=8",
               zero_flag, carry_flag, rf[2]);
    end
  endtask

  task automatic test_overflow;
    send(12'h00F); repeat (2) tick();
    send(12'h101); repeat (2) tick();
    send(12'h462); repeat (3) tick();
    checks++;
    if (ctl !== mk(0, 0, 1, 2'd3, 1, 1, 3'd0, 0, 4'd0) || dp_result !== 4'd0) begin
      errors++;
      $display("[TB] FAIL ovf_wb got ctl=%h res=%h expected ctl=%h res=0",
               ctl, dp_result, mk(0, 0, 1, 2'd3, 1, 1, 3'd0, 0, 4'd0));
    end
    repeat (2) tick();
    checks++;
    if ({zero_flag, carry_flag} !== 2'b11 || rf[3] !== 4'd0) begin
      errors++;
      $display("[TB] FAIL ovf_flags got z=%b c=%b r3=%h expected z=1 c=1 r3=0",
               zero_flag, carry_flag, rf[3]);
    end
    send(12'h205); repeat (2) tick();
    checks++;
    if ({zero_flag, carry_flag} !== 2'b11 || rf[2] !== 4'd5) begin
      errors++;
      $display("[TB] FAIL load_keeps_flags got z=%b c=%b r2=%h expected z=1 c=1 r2=5",
               zero_flag, carry_flag, rf[2]);
    end
  endtask

  task automatic test_class10;
    int wc;
    wc = writeCount;
`ifdef DPC_CMP_EN
    logic [14:0] e [0:5];
    e[0] = mk(0, 0, 0, 2'd2, 0, 0, 3'd0, 0, 4'd0);
    e[1] = mk(0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[2] = mk(0, 0, 0, 2'd0, 1, 0, 3'd0, 0, 4'd0);
    e[3] = mk(0, 0, 0, 2'd2, 1, 1, 3'd0, 0, 4'd0);
    e[4] = mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[5] = mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send(12'h850);
      else tick();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("[TB] FAIL cmp_cyc%0d ctl got %h expected %h", i, ctl, e[i]);
      end
    end
    // 5 + 15 = 20: result 4 with carry out
    checks++;
    if ({zero_flag, carry_flag} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL cmp_flags got z=%b c=%b expected z=0 c=1", zero_flag, carry_flag);
    end
`else
    send(12'h850);
    checks++;
    if (ctl !== mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0)) begin
      errors++;
      $display("[TB] FAIL nop_fin ctl got %h expected %h", ctl, mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0));
    end
    tick();
    checks++;
    if (ctl !== mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0) || {zero_flag, carry_flag} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL nop_after got ctl=%h z=%b c=%b expected ctl=%h z=1 c=1",
               ctl, zero_flag, carry_flag, mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0));
    end
`endif
    checks++;
    if (writeCount !== wc || rf[2] !== 4'd5) begin
      errors++;
      $display("[TB] FAIL class10_nowrite got writes=%0d r2=%h expected writes=%0d r2=5",
               writeCount, rf[2], wc);
    end
  endtask

  task automatic test_reset_mid;
    int wc;
    send(12'h442);
    tick();
    checks++;
    if (ctl !== mk(0, 0, 0, 2'd1, 0, 0, 3'd0, 0, 4'd0)) begin
      errors++;
      $display("[TB] FAIL rstmid_rdb ctl got %h expected %h", ctl, mk(0, 0, 0, 2'd1, 0, 0, 3'd0, 0, 4'd0));
    end
    wc = writeCount;
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== 15'd0 || {zero_flag, carry_flag} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rstmid_async got ctl=%h z=%b c=%b expected ctl=0 z=0 c=0",
               ctl, zero_flag, carry_flag);
    end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0)) begin
      errors++;
      $display("[TB] FAIL rstmid_release ctl got %h expected %h", ctl, mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0));
    end
    repeat (3) tick();
    checks++;
    if (writeCount !== wc || rf[2] !== 4'd5 || done !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_nowrite got writes=%0d r2=%h done=%b ill=%b expected writes=%0d r2=5 done=0 ill=0",
               writeCount, rf[2], done, illegal, wc);
    end
  endtask

  task automatic test_undef_op;
    logic [14:0] e [0:5];
    e[0] = mk(0, 0, 0, 2'd0, 0, 0, 3'd6, 1, 4'd0);
    e[1] = mk(0, 0, 0, 2'd1, 0, 0, 3'd6, 1, 4'd0);
    e[2] = mk(0, 0, 0, 2'd1, 1, 0, 3'd6, 1, 4'd0);
    e[3] = mk(0, 0, 1, 2'd0, 1, 1, 3'd6, 1, 4'd0);
    e[4] = mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    e[5] = mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send(12'h703);
      else tick();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("[TB] FAIL undef_cyc%0d ctl got %h expected %h", i, ctl, e[i]);
      end
    end
    checks++;
    if (rf[0] !== 4'd1 || {zero_flag, carry_flag} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL undef_result got r0=%h z=%b c=%b expected r0=1 z=0 c=0",
               rf[0], zero_flag, carry_flag);
    end
  endtask

  task automatic test_back_to_back;
    int wc;
    wc = writeCount;
    instr       = 12'hC00;
    instr_valid = 1'b1;
    tick();
    checks++;
    if (ctl !== mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0) || illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_fin got ctl=%h ill=%b expected ctl=%h ill=1",
               ctl, illegal, mk(0, 1, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0));
    end
    tick();
    checks++;
    if (ctl !== mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0) || writeCount !== wc) begin
      errors++;
      $display("[TB] FAIL illegal_idle got ctl=%h writes=%0d expected ctl=%h writes=%0d",
               ctl, writeCount, mk(1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 4'd0), wc);
    end
    instr = 12'h005;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (ctl !== mk(0, 0, 1, 2'd0, 0, 0, 3'd0, 0, 4'd5)) begin
      errors++;
      $display("[TB] FAIL b2b_load got ctl=%h expected %h", ctl, mk(0, 0, 1, 2'd0, 0, 0, 3'd0, 0, 4'd5));
    end
    repeat (2) tick();
    checks++;
    if (illegal !== 1'b1 || rf[0] !== 4'd5 || {zero_flag, carry_flag} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL illegal_sticky got ill=%b r0=%h z=%b c=%b expected ill=1 r0=5 z=0 c=0",
               illegal, rf[0], zero_flag, carry_flag);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_add();
    test_overflow();
    test_class10();
    test_reset_mid();
    test_undef_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
